// File: rtl/sys_pll_reset_sequencer.sv
// sys_pll_reset_sequencer
// Drives the system PLL reset from the free-running reference clock and
// holds the system in reset until PLL lock has been stable long enough.
// Lock timeouts and lock loss re-pulse the PLL reset and restart the sequence.

module sys_pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_rst,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [3:0] retry_count,
    output logic       lock_lost
);

    localparam int MAX_A      = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_CYCLES = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               sync_meta;
    logic               locked_s;
    logic [CNT_W-1:0]   count;
    logic               retry_inc;
    logic               lock_drop;

    assign state = state_q;

    // Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            locked_s  <= sync_meta;
        end
    end

    // Next-state selection; force_rst outranks lock events, which outrank the timeout
    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        lock_drop = 1'b0;
        case (state_q)
            PLL_RESET: begin
                if (count == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (force_rst) begin
                    state_d = PLL_RESET;
                end else if ((count >= FLUSH_CYCLES) && locked_s) begin
                    state_d = STABLE;
                end else if (count == TIMEOUT_LAST) begin
                    state_d   = PLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (force_rst) begin
                    state_d = PLL_RESET;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (count == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (force_rst) begin
                    state_d = PLL_RESET;
                end else if (!locked_s) begin
                    state_d   = PLL_RESET;
                    lock_drop = 1'b1;
                end
            end
            default: begin
                state_d = PLL_RESET;
            end
        endcase
    end

    // State register and shared counter, which restarts from zero on every state entry
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= PLL_RESET;
            count   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                count <= '0;
            end else if (state_q != RUN) begin
                count <= count + CNT_ONE;
            end
        end
    end

    // Registered reset outputs decoded from the state being entered
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            pll_rst <= (state_d == PLL_RESET);
            sys_rst <= (state_d != RUN);
            ready   <= (state_d == RUN);
        end
    end

    // Diagnostic counters that only the external reset clears
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            retry_count <= 4'd0;
            lock_lost   <= 1'b0;
        end else begin
            if (retry_inc && (retry_count != 4'd15)) begin
                retry_count <= retry_count + 4'd1;
            end
            if (lock_drop) begin
                lock_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sys_pll_reset_sequencer.sv
// tb_sys_pll_reset_sequencer
// Directed scenarios with hand-computed output changes; each expected change
// (absolute cycle plus all output values) is queued by the stimulus and the
// monitor pops one entry whenever the DUT outputs change.

module tb_sys_pll_reset_sequencer;

    typedef struct packed {
        logic [31:0] cyc;
        logic [9:0]  val;
    } exp_t;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       force_rst;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [3:0] retry_count;
    logic       lock_lost;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    exp_t       exp_q[$];
    string      name_q[$];
    logic [9:0] prev_snap = 'x;

    sys_pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES(8)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .force_rst(force_rst),
        .pll_rst(pll_rst),
        .sys_rst(sys_rst),
        .ready(ready),
        .state(state),
        .retry_count(retry_count),
        .lock_lost(lock_lost)
    );

    // 50 MHz reference clock
    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    // Cycle stamp: number of rising edges seen so far
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic r, input logic lk, input logic f);
        rst        = r;
        pll_locked = lk;
        force_rst  = f;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic push_expect(input string nm, input int at, input logic [1:0] st,
                               input logic pr, input logic sr, input logic rdy,
                               input logic [3:0] rc, input logic ll);
        exp_t e;
        e.cyc = 32'(at);
        e.val = {st, pr, sr, rdy, rc, ll};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic checkOutput(input logic [9:0] snap);
        exp_t  e;
        string nm;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL unexpected_change: cycle %0d got st=%0d pll_rst=%0b sys_rst=%0b ready=%0b retry=%0d lost=%0b, required no change",
                     cyc, snap[9:8], snap[7], snap[6], snap[5], snap[4:1], snap[0]);
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if ((e.cyc == 32'(cyc)) && (snap === e.val)) begin
                n_pass++;
            end else begin
                $display("[TB] FAIL %s: got cycle %0d st=%0d pll_rst=%0b sys_rst=%0b ready=%0b retry=%0d lost=%0b, required cycle %0d st=%0d pll_rst=%0b sys_rst=%0b ready=%0b retry=%0d lost=%0b",
                         nm, cyc, snap[9:8], snap[7], snap[6], snap[5], snap[4:1], snap[0],
                         e.cyc, e.val[9:8], e.val[7], e.val[6], e.val[5], e.val[4:1], e.val[0]);
            end
        end
    endtask

    // Monitor: compare against the scoreboard whenever any output changes
    always @(negedge refclk) begin
        logic [9:0] snap;
        snap = {state, pll_rst, sys_rst, ready, retry_count, lock_lost};
        if (snap !== prev_snap) begin
            checkOutput(snap);
            prev_snap = snap;
        end
    end

    initial begin
        int p;
        int q;
        int f;
        int g;
        int t;
        int w;
        int v;
        int rc;

        applyStimulus(1'b1, 1'b0, 1'b0);
        push_expect("reset_values", 1, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        wait_cycles(3);

        // Scenario 1: release reset, lock arrives 10 cycles later
        p = cyc;
        push_expect("s1_wait_lock", p + 4,  2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        push_expect("s1_stable",    p + 13, 2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        push_expect("s1_run",       p + 21, 2'd3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(10);
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_cycles(15);

        // Scenario 4: lock loss in RUN, relock, lock_lost stays set
        q = cyc;
        push_expect("s4_lost_pll_reset", q + 3,  2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s4_wait_lock",      q + 7,  2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s4_stable",         q + 11, 2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s4_run",            q + 19, 2'd3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_cycles(20);

        // Scenario 3: force restart, then a one-cycle lock glitch at stable count 5
        f = cyc;
        push_expect("s3_force_pll_reset", f + 1,  2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s3_wait_lock",       f + 5,  2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s3_stable_1",        f + 9,  2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s3_glitch_wait",     f + 15, 2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s3_stable_2",        f + 19, 2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s3_run",             f + 27, 2'd3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        wait_cycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_cycles(11);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_cycles(20);

        // Scenario 5: force on the timeout cycle and inside PLL_RESET,
        // then scenario 2: lock never returns and retries saturate
        g = cyc;
        push_expect("s5_lost_pll_reset",   g + 3,  2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s5_wait_lock",        g + 7,  2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s5_force_on_timeout", g + 39, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        push_expect("s5_pulse_not_extend", g + 43, 2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            t  = g + 75 + 36 * (k - 1);
            rc = (k > 15) ? 15 : k;
            push_expect($sformatf("s2_timeout_%0d", k), t,     2'd0, 1'b1, 1'b1, 1'b0, 4'(rc), 1'b1);
            push_expect($sformatf("s2_rewait_%0d", k),  t + 4, 2'd1, 1'b0, 1'b1, 1'b0, 4'(rc), 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(38);
        applyStimulus(1'b0, 1'b0, 1'b1);
        wait_cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        wait_cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Scenario 6: reach STABLE, then assert rst between clock edges
        w = g + 75 + 36 * 16 + 4;
        wait_cycles(w + 5 - cyc);
        push_expect("s6_stable", w + 8, 2'd2, 1'b0, 1'b1, 1'b0, 4'd15, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_cycles(6);
        push_expect("s6_async_reset", cyc, 2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        #2;
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_cycles(2);
        v = cyc;
        push_expect("s6_wait_lock", v + 4,  2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        push_expect("s6_stable_2",  v + 8,  2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        push_expect("s6_run",       v + 16, 2'd3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_cycles(22);

        // Any expected change that never happened is a failed check
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            $display("[TB] FAIL %s: got no output change, required change at cycle %0d", nm, e.cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
